maxpool2x2_stream: RTL and testbench
====================================

MAXPOOL2X2_STREAM -- requirements
Module: maxpool2x2_stream

Interface
REQ-001 Parameter IntSize, 8, pixel width in bits, signed two's complement.
REQ-002 Parameter PicWidth, 28, input frame width and height in pixels; legal values are even numbers from 4 to 64 (28 = stage 1, 14 = stage 2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  IntSize  conv-output pixel, raster order, row-major.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_data  output  IntSize  pooled pixel, raster order.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 frame_done  output  1  one-cycle pulse in the cycle the last pooled pixel of a frame is accepted.

Function
REQ-012 An input beat SHALL occur when in_valid and in_ready are both high; an output beat SHALL occur when out_valid and out_ready are both high.
REQ-013 Counters col and row SHALL both range over 0..PicWidth-1; col SHALL increment on each input beat and wrap to 0 after PicWidth-1, at which point row SHALL increment; row SHALL wrap to 0 after PicWidth-1.
REQ-014 On an even-col beat, the block SHALL hold the pixel in a pair register.
REQ-015 On an odd-col beat with even row, the block SHALL write signed max(pair, in_data) into line buffer entry col/2 (PicWidth/2 entries).
REQ-016 On an odd-col beat with odd row, the block SHALL load out_data with signed max(linebuf[col/2], pair, in_data) and set out_valid in the next cycle (latency 1 cycle).
REQ-017 All comparisons SHALL be signed; on ties either operand is acceptable because the values are equal; no widening or saturation.
REQ-018 in_ready SHALL equal !(out_valid && !out_ready), so a pending unaccepted output stalls input, and simultaneous accept-out and accept-in is permitted in the same cycle.
REQ-019 out_valid SHALL stay high with out_data stable until the output beat.
REQ-020 An output counter SHALL count output beats 0..(PicWidth/2)^2-1; frame_done SHALL pulse on the beat at the final count, and the counter SHALL wrap to 0 in the same cycle.
REQ-021 A new frame SHALL be accepted back-to-back with no idle cycle, and line buffer contents SHALL NOT need clearing between frames.
REQ-022 Exactly (PicWidth/2)^2 outputs SHALL be produced per PicWidth^2 inputs.

Reset
REQ-023 On rst_n low, at any time including mid-frame, col, row, and the output counter SHALL be cleared to 0, and out_valid, frame_done, and out_data SHALL be cleared to 0.
REQ-024 After reset, in_ready SHALL be 1, and the next input beat SHALL be treated as pixel (0,0) of a new frame.
REQ-025 Line buffer and pair register contents SHALL NOT need reset.

Configuration
REQ-026 With macro MAXPOOL_FUSED_RELU_EN defined, every in_data SHALL be clamped to 0 when negative before any comparison, so out_data is never negative.
REQ-027 Without MAXPOOL_FUSED_RELU_EN, raw signed values SHALL be pooled and negative outputs are legal.

Structure
REQ-028 Shared package cnn_pkg SHALL hold IntSize, the PicSize1/2/3 constants (784/196/49), the stage widths 28/14/7, and the pixel_t signed typedef.
REQ-029 The signed two-input max SHALL be a sub-module named pool_max2, instantiated twice.
REQ-030 Line buffer SHALL be a register array of PicWidth/2 entries of IntSize bits.

Verification
REQ-031 PicWidth=4, inputs 0..15 streamed with out_ready=1 -> outputs 5,7,13,15; frame_done pulses with 15.
REQ-032 PicWidth=4, all inputs -128 except (1,1)=-3 -> first output -3, others -128; with MAXPOOL_FUSED_RELU_EN -> all outputs 0.
REQ-033 out_ready=0 after first output -> in_ready drops, out_data held; raising out_ready -> resumes with no lost or duplicated pixel.
REQ-034 rst_n pulsed low after 9 input beats of a 4x4 frame -> out_valid=0 immediately; a fresh 0..15 frame then yields 5,7,13,15.
REQ-035 PicWidth=28, two back-to-back random frames with continuous in_valid -> 196 outputs each matching a golden model, and exactly two frame_done pulses.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN constants: pixel width, per-stage frame sizes and widths,
// and the signed pixel type used across the pooling and convolution blocks.
package cnn_pkg;

  localparam int IntSize = 8;

  localparam int Stage1Width = 28;
  localparam int Stage2Width = 14;
  localparam int Stage3Width = 7;

  localparam int PicSize1 = Stage1Width * Stage1Width;  // 784
  localparam int PicSize2 = Stage2Width * Stage2Width;  // 196
  localparam int PicSize3 = Stage3Width * Stage3Width;  // 49

  typedef logic signed [IntSize-1:0] pixel_t;

endpackage

// File: rtl/pool_max2.sv
// Signed two-input maximum, the basic comparator of the 2x2 pooling window.
module pool_max2 #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  // Pick the larger operand; on a tie both operands carry the same value.
  always_comb begin
    y = (a > b) ? a : b;
  end

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 max-pool over a PicWidth x PicWidth raster frame.
// Even rows are folded pairwise into a half-width line buffer; odd rows
// combine the buffered pair maximum with the current pair to emit one
// pooled pixel per 2x2 window, one cycle after the closing input beat.
// Optional build macro MAXPOOL_FUSED_RELU_EN: clamps negative input
// pixels to zero before pooling, so every pooled output is non-negative.
module maxpool2x2_stream #(
  parameter int IntSize  = cnn_pkg::IntSize,
  parameter int PicWidth = cnn_pkg::Stage1Width
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IntSize-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [IntSize-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_done
);

  import cnn_pkg::*;

  localparam int Half = PicWidth / 2;
  localparam int NOut = Half * Half;
  localparam int CW   = $clog2(PicWidth);
  localparam int OW   = $clog2(NOut);

  localparam logic [CW-1:0] PosLast = CW'(PicWidth - 1);
  localparam logic [OW-1:0] OutLast = OW'(NOut - 1);

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [OW-1:0] out_cnt;
  logic [CW-2:0] lb_idx;

  logic in_beat;
  logic out_beat;

  logic signed [IntSize-1:0] pix_p0;
  logic signed [IntSize-1:0] pair;
  logic signed [IntSize-1:0] lb_rd;
  logic signed [IntSize-1:0] max_pair;
  logic signed [IntSize-1:0] max_quad;
  logic signed [IntSize-1:0] linebuf [Half];

  logic signed [IntSize-1:0] pool_p1;
  logic                      vld_p1;

`ifdef MAXPOOL_FUSED_RELU_EN
  function automatic logic signed [IntSize-1:0] relu(input logic signed [IntSize-1:0] x);
    return x[IntSize-1] ? '0 : x;
  endfunction

  // Stage 0: clamp negative pixels to zero ahead of every comparison.
  always_comb begin
    pix_p0 = relu($signed(in_data));
  end
`else
  // Stage 0: raw signed pixel goes straight into the comparators.
  always_comb begin
    pix_p0 = $signed(in_data);
  end
`endif

  // Handshakes: an unaccepted pending output is the only thing that stalls input.
  always_comb begin
    in_ready = !(vld_p1 && !out_ready);
    in_beat  = in_valid && in_ready;
    out_beat = vld_p1 && out_ready;
    lb_idx   = col[CW-1:1];
    lb_rd    = linebuf[lb_idx];
  end

  pool_max2 #(.W(IntSize)) u_max_pair (
    .a (pair),
    .b (pix_p0),
    .y (max_pair)
  );

  pool_max2 #(.W(IntSize)) u_max_quad (
    .a (lb_rd),
    .b (max_pair),
    .y (max_quad)
  );

  // Raster position of the next input pixel; wraps at frame end for back-to-back frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_beat) begin
      if (col == PosLast) begin
        col <= '0;
        row <= (row == PosLast) ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Window datapath: hold the even-column pixel, fold even-row pairs into the line buffer.
  always_ff @(posedge clk) begin
    if (in_beat && !col[0]) begin
      pair <= pix_p0;
    end
    if (in_beat && col[0] && !row[0]) begin
      linebuf[lb_idx] <= max_pair;
    end
  end

  // Stage 1: pooled result register, held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      pool_p1 <= '0;
    end else if (in_beat && col[0] && row[0]) begin
      vld_p1  <= 1'b1;
      pool_p1 <= max_quad;
    end else if (out_beat) begin
      vld_p1  <= 1'b0;
    end
  end

  // Output beat counter marks the last pooled pixel of each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (out_beat) begin
      out_cnt <= (out_cnt == OutLast) ? '0 : out_cnt + OW'(1);
    end
  end

  // Outputs driven from the stage-1 registers and the output counter.
  always_comb begin
    out_valid  = vld_p1;
    out_data   = pool_p1;
    frame_done = out_beat && (out_cnt == OutLast);
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: a 4x4 instance for directed frames and a
// 28x28 instance for back-to-back random frames, checked against a
// frame-array model of 2x2 window maxima plus literal expectations.
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_frame_done;
  logic signed [7:0] a_in_data, a_out_data;
  logic              b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
  logic signed [7:0] b_in_data, b_out_data;

  maxpool2x2_stream #(.IntSize(8), .PicWidth(4)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .frame_done(a_frame_done)
  );

  maxpool2x2_stream #(.IntSize(8), .PicWidth(28)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .frame_done(b_frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state, index 0 = 4x4 instance, 1 = 28x28 instance
  int img   [2][64][64];
  int exp_d [2][256];
  int wr    [2];
  int rd    [2];
  int pos   [2];
  int oc    [2];
  int nout  [2];
  int nfd   [2];
  bit held  [2];
  int hold_d[2];

  // literal expectations for the 4x4 instance, written only by the stimulus
  int lit_d [32];
  bit lit_f [32];
  int lit_n = 0;
  int lit_i = 0;

  int tmo = 0;
  bit done_req = 0;
  bit done_seen = 0;
  int b_frame [1568];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int relu_m(input int x);
`ifdef MAXPOOL_FUSED_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  task automatic step(input int k, input int w, input logic rstn,
                      input logic iv, input logic ir, input logic signed [7:0] id,
                      input logic ov, input logic ordy, input logic signed [7:0] od,
                      input logic fd);
    string p;
    int    r, c, m, e, px, n;
    bit    fd_exp;
    p = (k == 0) ? "a" : "b";
    n = (w / 2) * (w / 2);
    if (!rstn) begin
      chk({p, "_rst_out_valid"}, int'(ov), 0);
      chk({p, "_rst_out_data"}, int'(od), 0);
      chk({p, "_rst_in_ready"}, int'(ir), 1);
      chk({p, "_rst_frame_done"}, int'(fd), 0);
      pos[k] = 0; wr[k] = 0; rd[k] = 0; oc[k] = 0; held[k] = 0;
    end else begin
      chk({p, "_in_ready"}, int'(ir), int'(!(ov && !ordy)));
      if (held[k]) begin
        chk({p, "_hold_valid"}, int'(ov), 1);
        chk({p, "_hold_data"}, int'(od), hold_d[k]);
      end
      held[k]   = ov && !ordy;
      hold_d[k] = int'(od);
      fd_exp = 0;
      if (ov && ordy) begin
        chk({p, "_out_pending"}, int'(wr[k] != rd[k]), 1);
        if (wr[k] != rd[k]) begin
          e = exp_d[k][rd[k] % 256];
          rd[k]++;
          chk({p, "_out_data"}, int'(od), e);
        end
        fd_exp = (oc[k] == n - 1);
        oc[k]  = (oc[k] + 1) % n;
        nout[k]++;
        if (k == 0 && lit_i < lit_n) begin
          chk("a_lit_data", int'(od), lit_d[lit_i]);
          chk("a_lit_done", int'(fd), int'(lit_f[lit_i]));
          lit_i++;
        end
      end
      chk({p, "_frame_done"}, int'(fd), int'(fd_exp));
      if (fd) nfd[k]++;
      if (iv && ir) begin
        px = relu_m(int'(id));
        r  = pos[k] / w;
        c  = pos[k] % w;
        img[k][r][c] = px;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          m = img[k][r][c];
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (img[k][r-dr][c-dc] > m) m = img[k][r-dr][c-dc];
          exp_d[k][wr[k] % 256] = m;
          wr[k]++;
        end
        pos[k] = (pos[k] + 1) % (w * w);
      end
    end
  endtask

  // single compare process, sampling on the falling edge
  always @(negedge clk) begin
    step(0, 4, a_rst_n, a_in_valid, a_in_ready, a_in_data, a_out_valid, a_out_ready, a_out_data, a_frame_done);
    step(1, 28, b_rst_n, b_in_valid, b_in_ready, b_in_data, b_out_valid, b_out_ready, b_out_data, b_frame_done);
    if (done_req && !done_seen) begin
      chk("a_lit_count", lit_i, lit_n);
      chk("a_model_drained", wr[0] - rd[0], 0);
      chk("b_model_drained", wr[1] - rd[1], 0);
      chk("b_output_count", nout[1], 392);
      chk("b_frame_done_count", nfd[1], 2);
      chk("handshake_timeouts", tmo, 0);
      done_seen = 1;
    end
  end

  task automatic add_lit(input int d, input bit f);
    lit_d[lit_n] = d;
    lit_f[lit_n] = f;
    lit_n++;
  endtask

  task automatic send_a(input int v[16], input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int t;
      bit acc;
      a_in_data  = 8'(v[i]);
      a_in_valid = 1'b1;
      t = 0;
      acc = 0;
      while (!acc && t < 100) begin
        @(negedge clk);
        acc = a_in_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) tmo++;
    end
    a_in_valid = 1'b0;
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  initial begin
    int ramp [16];
    int neg  [16];
    for (int i = 0; i < 16; i++) begin
      ramp[i] = i;
      neg[i]  = -128;
    end
    neg[5] = -3;
    for (int i = 0; i < 1568; i++) b_frame[i] = int'($urandom_range(255)) - 128;

    a_rst_n = 0; b_rst_n = 0;
    a_in_valid = 0; b_in_valid = 0;
    a_in_data = '0; b_in_data = '0;
    a_out_ready = 1; b_out_ready = 1;
    idle(3);
    a_rst_n = 1; b_rst_n = 1;
    idle(2);

    // ramp frame 0..15
    add_lit(5, 0); add_lit(7, 0); add_lit(13, 0); add_lit(15, 1);
    send_a(ramp, 16);
    idle(4);

    // all -128 except (1,1) = -3
`ifdef MAXPOOL_FUSED_RELU_EN
    add_lit(0, 0); add_lit(0, 0); add_lit(0, 0); add_lit(0, 1);
`else
    add_lit(-3, 0); add_lit(-128, 0); add_lit(-128, 0); add_lit(-128, 1);
`endif
    send_a(neg, 16);
    idle(4);

    // consumer stalls from the first output, then resumes
    add_lit(5, 0); add_lit(7, 0); add_lit(13, 0); add_lit(15, 1);
    a_out_ready = 0;
    fork
      send_a(ramp, 16);
      begin
        idle(12);
        a_out_ready = 1;
      end
    join
    idle(4);

    // reset after 9 beats, then a fresh frame
    add_lit(5, 0); add_lit(7, 0);
    send_a(ramp, 9);
    a_rst_n = 0;
    idle(2);
    a_rst_n = 1;
    idle(1);
    add_lit(5, 0); add_lit(7, 0); add_lit(13, 0); add_lit(15, 1);
    send_a(ramp, 16);
    idle(4);

    // two back-to-back random 28x28 frames with continuous in_valid
    for (int i = 0; i < 1568; i++) begin
      int t;
      bit acc;
      b_in_data  = 8'(b_frame[i]);
      b_in_valid = 1'b1;
      t = 0;
      acc = 0;
      while (!acc && t < 100) begin
        @(negedge clk);
        acc = b_in_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) tmo++;
    end
    b_in_valid = 1'b0;
    idle(6);

    done_req = 1;
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
